alu_div_multi: RTL and testbench
================================

Name: alu_div_multi

Overview:
- Parametrised successor to the fpunit lane divider.
- L independent lanes of N-bit integer division, computed by an iterative radix-2 restoring datapath (one quotient bit per lane per cycle).
- Adds a per-operation signed/unsigned mode, per-lane divide-by-zero flags and a ready output.
- Keeps the existing ivalid/stall/finish contract, so the fpunit issue logic drives it unchanged.

Parameters:
- N, 32: lane width in bits (>=2).
- L, 4: lane count.
- SIGNED_EN, 1: 1 = signed mode supported; 0 = signed_mode input ignored, all ops unsigned.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ivalid  in  1  operation request; must stay high until the result is consumed.
- stall  in  1  downstream not ready; holds the result while finish=1.
- signed_mode  in  1  sampled at accept; 1 = two's-complement division.
- a  in  N*L  dividends; lane i = a[N*i+N-1:N*i].
- b  in  N*L  divisors, same packing.
- ready  out  1  high in IDLE only.
- q  out  N*L  quotients.
- r  out  N*L  remainders.
- div_zero  out  L  per-lane flag: divisor was zero.
- finish  out  1  results valid.

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, q=0, r=0, div_zero=0, finish=0, ready=1. Mid-operation reset discards all work immediately.
- FSM states: IDLE, BUSY, FIX, DONE.
- IDLE:
  - ivalid=1 at an edge: capture a, b and signed_mode.
  - Compute operand magnitudes and the quotient/remainder signs.
  - count=0, go to BUSY.
- BUSY:
  - Each edge performs one restoring step on every lane and increments count.
  - After N steps (count==N-1 at the edge), go to FIX.
- FIX: apply sign correction, load q, r and div_zero, go to DONE.
- DONE:
  - finish=1; q, r and div_zero held stable.
  - stall=0 at an edge: go to IDLE.
  - stall=1: stay in DONE.
- Latency: with the accept edge as E0, finish rises after edge E(N+1), i.e. N+1 cycles (33 at N=32).
- Throughput: one operation per N+3 cycles when stall=0 and ivalid is held.
- Abort: ivalid=0 at any edge while in BUSY, FIX or DONE forces IDLE next edge.
  - finish drops at that edge.
  - q, r and div_zero keep their last values.
  - This preserves the existing "drop ivalid clears counter" rule.
- Unsigned arithmetic: q = floor(a/b), r = a - q*b.
- Signed arithmetic:
  - Divide magnitudes.
  - q is negated when the operand signs differ (truncation toward zero).
  - r takes the sign of the dividend.
- Signed overflow, MIN / -1: q = MIN (0x80000000 at N=32), r = 0. No flag is raised.
- Divide by zero (either mode): q = all ones, r = a, div_zero[i] = 1.
  - Other lanes of the same operation are unaffected.
  - div_zero clears at the next FIX load.
- Lanes are fully independent; all lanes share one count and one FSM.
- signed_mode, a and b changing during BUSY have no effect, because operands are captured at accept.

Decomposition:
- Package alu_div_pkg:
  - state enum {IDLE, BUSY, FIX, DONE};
  - localparam CNT_W = $clog2(N+1);
  - a function for the latency constant N+1, used by the bench.
- Sub-module alu_div_lane, instantiated L times in a generate loop. Per lane it holds:
  - magnitude capture;
  - partial-remainder/quotient shift registers;
  - the restoring subtract step;
  - sign fix-up;
  - the zero-divisor detect.
  The top level holds the FSM, count, ready/finish and the lane packing.

Test Plan:
- Unsigned (N=32, L=4): a={100, 7, 0xFFFFFFFF, 5}, b={7, 100, 16, 5} -> q={14, 0, 0x0FFFFFFF, 1}, r={2, 7, 15, 0}; finish first high 33 cycles after the accept edge.
- Signed: lane pairs (-7,2), (7,-2), (-7,-2), (0x80000000,-1) -> q={0xFFFFFFFD, 0xFFFFFFFD, 3, 0x80000000}, r={0xFFFFFFFF, 1, 0xFFFFFFFF, 0}. Same operands with signed_mode=0 give unsigned results.
- Divide by zero: lane0 a=1234, b=0; other lanes 10/3 -> lane0 q=0xFFFFFFFF, r=1234, div_zero=4'b0001; other lanes q=3, r=1.
- Stall hold: stall=1 for 5 cycles after finish -> q, r and finish stable throughout. Deassert stall -> IDLE next edge, ready=1; a back-to-back op is accepted and correct.
- Abort: ivalid=0 at BUSY count=10 -> IDLE next edge, finish never asserts; the following op 81/9 returns q=9, r=0.
- Async reset: assert rst mid-BUSY between clock edges -> q, r, div_zero and finish go to 0 and ready to 1 without waiting for clk; a normal op after release completes correctly.

Source files
------------

// File: rtl/alu_div_pkg.sv
// alu_div_pkg: shared FSM states and sizing helpers for the lane divider.
package alu_div_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

   localparam int N_DEF = 32;
   localparam int CNT_W = $clog2(N_DEF + 1);

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   // Cycles from the accept edge until finish is first high.
   function automatic int latency(input int n);
      return n + 1;
   endfunction

endpackage

// File: rtl/alu_div_lane.sv
// alu_div_lane: one lane of the radix-2 restoring divider with sign handling
// and zero-divisor detect.
module alu_div_lane
   import alu_div_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_step,
   input  logic         i_fix,
   input  logic         i_sgn,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_q,
   output logic [N-1:0] o_r,
   output logic         o_dz
);

   logic [N-1:0] r_a, r_b, r_rem, r_quo;
   logic         r_neg_q, r_neg_r, r_zero;
   logic         w_a_neg, w_b_neg, w_fit;
   logic [N-1:0] w_mag_a, w_mag_b;
   logic [N:0]   w_shift, w_diff;

   assign w_a_neg = i_sgn & i_a[N-1];
   assign w_b_neg = i_sgn & i_b[N-1];
   assign w_mag_a = w_a_neg ? -i_a : i_a;
   assign w_mag_b = w_b_neg ? -i_b : i_b;
   // r_quo starts as the dividend and shifts its bits into the remainder.
   assign w_shift = {r_rem, r_quo[N-1]};
   assign w_diff  = w_shift - {1'b0, r_b};
   assign w_fit   = ~w_diff[N];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_zero  <= 1'b0;
         o_q     <= '0;
         o_r     <= '0;
         o_dz    <= 1'b0;
      end else begin
         if (i_load) begin
            r_a     <= i_a;
            r_b     <= w_mag_b;
            r_rem   <= '0;
            r_quo   <= w_mag_a;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_zero  <= (i_b == '0);
         end
         if (i_step) begin
            r_rem <= w_fit ? w_diff[N-1:0] : w_shift[N-1:0];
            r_quo <= {r_quo[N-2:0], w_fit};
         end
         if (i_fix) begin
            o_q  <= r_zero ? '1 : (r_neg_q ? -r_quo : r_quo);
            o_r  <= r_zero ? r_a : (r_neg_r ? -r_rem : r_rem);
            o_dz <= r_zero;
         end
      end
   end

endmodule

// File: rtl/alu_div_multi.sv
// alu_div_multi: L-lane iterative integer divider; shared FSM and step count,
// per-lane datapaths in alu_div_lane.
module alu_div_multi
   import alu_div_pkg::*;
#(
   parameter int N         = 32,
   parameter int L         = 4,
   parameter int SIGNED_EN = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ivalid,
   input  logic           stall,
   input  logic           signed_mode,
   input  logic [N*L-1:0] a,
   input  logic [N*L-1:0] b,
   output logic           ready,
   output logic [N*L-1:0] q,
   output logic [N*L-1:0] r,
   output logic [L-1:0]   div_zero,
   output logic           finish
);

   localparam int CW = cnt_width(N);

   state_t        r_state, w_next;
   logic [CW-1:0] r_count;
   logic          w_load, w_step, w_fix, w_sgn;

   assign w_load = (r_state == IDLE) && ivalid;
   assign w_step = (r_state == BUSY) && ivalid;
   assign w_fix  = (r_state == FIX) && ivalid;
   assign w_sgn  = signed_mode && (SIGNED_EN != 0);
   assign ready  = (r_state == IDLE);
   assign finish = (r_state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         r_count <= w_step ? r_count + 1'b1 : '0;
      end
   end

   // Dropping ivalid outside IDLE abandons the operation.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = ivalid ? BUSY : IDLE;
         BUSY:    w_next = !ivalid ? IDLE : (r_count == CW'(N - 1)) ? FIX : BUSY;
         FIX:     w_next = ivalid ? DONE : IDLE;
         DONE:    w_next = (ivalid && stall) ? DONE : IDLE;
         default: w_next = IDLE;
      endcase
   end

   for (genvar i = 0; i < L; i++) begin : g_lane
      alu_div_lane #(.N(N)) u_lane (
         .clk    (clk),
         .rst    (rst),
         .i_load (w_load),
         .i_step (w_step),
         .i_fix  (w_fix),
         .i_sgn  (w_sgn),
         .i_a    (a[N*i +: N]),
         .i_b    (b[N*i +: N]),
         .o_q    (q[N*i +: N]),
         .o_r    (r[N*i +: N]),
         .o_dz   (div_zero[i])
      );
   end

endmodule

// File: tb/tb_alu_div_multi.sv
// tb_alu_div_multi: table-driven vectors plus stall, abort and async-reset sequences.
module tb_alu_div_multi;
   import alu_div_pkg::*;

   typedef struct {
      logic         sm;
      logic [127:0] a, b, q, r;
      logic [3:0]   dz;
   } vec_t;

   logic         clk, rst, ivalid, stall, signed_mode, ready, finish;
   logic [127:0] a, b, q, r;
   logic [3:0]   div_zero;
   int           errors = 0, checks = 0;
   vec_t         v[7];

   alu_div_multi #(.N(32), .L(4), .SIGNED_EN(1)) dut (
      .clk(clk), .rst(rst), .ivalid(ivalid), .stall(stall), .signed_mode(signed_mode),
      .a(a), .b(b), .ready(ready), .q(q), .r(r), .div_zero(div_zero), .finish(finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] p4(input logic [31:0] x0, x1, x2, x3);
      return {x3, x2, x1, x0};
   endfunction

   function automatic vec_t mk(input logic sm, input logic [127:0] ta, tb, tq, tr, input logic [3:0] tdz);
      vec_t t;
      t.sm = sm; t.a = ta; t.b = tb; t.q = tq; t.r = tr; t.dz = tdz;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at a sample point; returns just after the accept edge.
   task automatic start_op(input vec_t t);
      chk("ready_before_accept", 128'(ready), 128'(1));
      a = t.a; b = t.b; signed_mode = t.sm; ivalid = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic wait_finish(output int lat);
      lat = 0;
      while (!finish && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_res(input string nm, input vec_t t);
      chk({nm, "_q"}, q, t.q);
      chk({nm, "_r"}, r, t.r);
      chk({nm, "_dz"}, 128'(div_zero), 128'(t.dz));
   endtask

   task automatic run_vec(input string nm, input vec_t t);
      int lat;
      start_op(t);
      wait_finish(lat);
      chk({nm, "_latency"}, 128'(lat), 128'(latency(32)));
      check_res(nm, t);
      ivalid = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_ready_after"}, 128'(ready), 128'(1));
      chk({nm, "_finish_after"}, 128'(finish), 128'(0));
   endtask

   initial begin
      int  lat;
      logic saw;
      v[0] = mk(0, p4(100, 7, 32'hFFFFFFFF, 5), p4(7, 100, 16, 5),
                p4(14, 0, 32'h0FFFFFFF, 1), p4(2, 7, 15, 0), 4'b0000);
      v[1] = mk(1, p4(32'hFFFFFFF9, 7, 32'hFFFFFFF9, 32'h80000000),
                p4(2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF),
                p4(32'hFFFFFFFD, 32'hFFFFFFFD, 3, 32'h80000000),
                p4(32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0), 4'b0000);
      v[2] = mk(0, v[1].a, v[1].b, p4(32'h7FFFFFFC, 0, 0, 0),
                p4(1, 7, 32'hFFFFFFF9, 32'h80000000), 4'b0000);
      v[3] = mk(0, p4(1234, 10, 10, 10), p4(0, 3, 3, 3),
                p4(32'hFFFFFFFF, 3, 3, 3), p4(1234, 1, 1, 1), 4'b0001);
      v[4] = mk(1, p4(32'hFFFFFFFB, 32'hFFFFFFF6, 10, 0), p4(0, 3, 32'hFFFFFFFD, 0),
                p4(32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF),
                p4(32'hFFFFFFFB, 32'hFFFFFFFF, 1, 0), 4'b1001);
      v[5] = mk(0, p4(81, 32'hFFFFFFFF, 1, 0), p4(9, 1, 32'hFFFFFFFF, 1),
                p4(9, 32'hFFFFFFFF, 0, 0), p4(0, 0, 1, 0), 4'b0000);
      v[6] = mk(0, p4(81, 81, 81, 81), p4(9, 9, 9, 9),
                p4(9, 9, 9, 9), p4(0, 0, 0, 0), 4'b0000);

      ivalid = 1'b0; stall = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("reset_q", q, '0);
      chk("reset_r", r, '0);
      chk("reset_dz", 128'(div_zero), 128'(0));
      chk("reset_finish", 128'(finish), 128'(0));
      chk("reset_ready", 128'(ready), 128'(1));
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), v[i]);

      // Stall hold then back-to-back accept.
      stall = 1'b1;
      start_op(v[0]);
      wait_finish(lat);
      chk("stall_latency", 128'(lat), 128'(latency(32)));
      check_res("stall_first", v[0]);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("stall_finish_%0d", k), 128'(finish), 128'(1));
         chk($sformatf("stall_q_%0d", k), q, v[0].q);
         chk($sformatf("stall_r_%0d", k), r, v[0].r);
      end
      stall = 1'b0;
      a = v[5].a; b = v[5].b; signed_mode = v[5].sm;
      @(posedge clk); #1;
      chk("unstall_ready", 128'(ready), 128'(1));
      chk("unstall_finish", 128'(finish), 128'(0));
      @(posedge clk); #1;
      wait_finish(lat);
      chk("b2b_latency", 128'(lat), 128'(latency(32)));
      check_res("b2b", v[5]);
      ivalid = 1'b0;
      @(posedge clk); #1;

      // Abort at count=10.
      start_op(v[0]);
      repeat (10) @(posedge clk);
      #1 ivalid = 1'b0;
      @(posedge clk); #1;
      chk("abort_ready", 128'(ready), 128'(1));
      saw = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (finish) saw = 1'b1;
      end
      chk("abort_no_finish", 128'(saw), 128'(0));
      chk("abort_q_kept", q, v[5].q);
      chk("abort_r_kept", r, v[5].r);
      run_vec("after_abort", v[6]);

      // Asynchronous reset between clock edges.
      run_vec("pre_reset", v[4]);
      start_op(v[0]);
      repeat (5) @(posedge clk);
      #4 rst = 1'b1;
      #1;
      chk("areset_q", q, '0);
      chk("areset_r", r, '0);
      chk("areset_dz", 128'(div_zero), 128'(0));
      chk("areset_finish", 128'(finish), 128'(0));
      chk("areset_ready", 128'(ready), 128'(1));
      ivalid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_vec("post_reset", v[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
